hs32_sram_arb: RTL

Two-master access arbiter placed between the hs32 core's memory port, the management Wishbone slave bus and port 0 of one `sram_1rw1r_32_256_8_sky130` macro. It grants one master per transaction and drives the macro's active-low chip-select and write-enable, byte mask, address and write data. It captures the macro's read data and returns a single-cycle acknowledge, so the management SoC can load and inspect core memory while the core runs.

---
 rtl/hs32_sram_pkg.sv | 7 +
 rtl/hs32_sram_arb_if.sv | 24 ++
 rtl/hs32_rr_arb2.sv | 17 +
 rtl/hs32_sram_arb.sv | 85 ++++++++
 4 files changed

// File: rtl/hs32_sram_pkg.sv
// hs32_sram_pkg: FSM states, master IDs and latencies shared by the hs32 SRAM arbiter
package hs32_sram_pkg;
  typedef enum logic [1:0] {IDLE, RDATA, ACK} state_e;
  typedef enum logic {MST_CPU = 1'b0, MST_WB = 1'b1} mst_e;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;
endpackage

// File: rtl/hs32_sram_arb_if.sv
// hs32_sram_arb_if: core port, management Wishbone slave and SRAM port-0 signals of the arbiter
interface hs32_sram_arb_if #(parameter int ADDR_W = 8);
  logic              cpu_stb_i, cpu_we_i, cpu_ack_o;
  logic [3:0]        cpu_sel_i;
  logic [ADDR_W-1:0] cpu_adr_i;
  logic [31:0]       cpu_dat_i, cpu_dat_o;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ack_o;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic              csb0, web0;
  logic [3:0]        wmask0;
  logic [ADDR_W-1:0] addr0;
  logic [31:0]       din0, dout0;
  modport slave (
    input  cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, dout0,
    output cpu_ack_o, cpu_dat_o, wbs_ack_o, wbs_dat_o, csb0, web0, wmask0, addr0, din0
  );
  modport master (
    output cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, dout0,
    input  cpu_ack_o, cpu_dat_o, wbs_ack_o, wbs_dat_o, csb0, web0, wmask0, addr0, din0
  );
endinterface

// File: rtl/hs32_rr_arb2.sv
// hs32_rr_arb2: 2-request round-robin arbiter; the last-grant pointer moves only when upd_i is high
module hs32_rr_arb2
  import hs32_sram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output mst_e       gnt_o
);
  mst_e last_q;
  // Pointer resets to WB so the CPU wins the first contested cycle
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) last_q <= MST_WB;
    else if (upd_i) last_q <= gnt_o;
  assign gnt_o = (req_i[1] && (!req_i[0] || last_q == MST_CPU)) ? MST_WB : MST_CPU;
endmodule

// File: rtl/hs32_sram_arb.sv
// hs32_sram_arb: CPU / management-Wishbone arbiter for port 0 of an sky130 SRAM macro
// Wishbone path and round-robin arbitration exist only when HS32_SRAM_ARB_WB_EN is defined.
module hs32_sram_arb
  import hs32_sram_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter logic [31:0] WB_BASE = 32'h3000_0000,
  parameter logic [31:0] WB_MASK = 32'hFFFF_FC00
) (
  input logic            wb_clk_i,
  input logic            wb_rst_ni,
  hs32_sram_arb_if.slave bus
);
  state_e            state_q, state_d;
  mst_e              gnt_q, gnt_d, gnt, cur;
  logic              wb_req, req, acc, we;
  logic [3:0]        sel, wmask_q;
  logic [ADDR_W-1:0] adr, addr_q;
  logic [31:0]       dat, din_q, cpu_dat_q, wbs_dat_q;
  logic              cpu_ack_q, cpu_ack_d, wbs_ack_q, wbs_ack_d;
`ifdef HS32_SRAM_ARB_WB_EN
  assign wb_req = bus.wbs_cyc_i & bus.wbs_stb_i & ((bus.wbs_adr_i & WB_MASK) == WB_BASE);
  hs32_rr_arb2 u_rr (
    .clk_i (wb_clk_i),
    .rst_ni(wb_rst_ni),
    .req_i ({wb_req, bus.cpu_stb_i}),
    .upd_i (acc),
    .gnt_o (gnt)
  );
  // A master that drops cyc mid-transfer never sees the ack
  assign bus.wbs_ack_o = wbs_ack_q & bus.wbs_cyc_i;
  assign bus.wbs_dat_o = wbs_dat_q;
`else
  logic unused_wb;
  assign wb_req        = 1'b0;
  assign gnt           = MST_CPU;
  assign bus.wbs_ack_o = 1'b0;
  assign bus.wbs_dat_o = 32'h0;
  assign unused_wb     = ^{bus.wbs_cyc_i, bus.wbs_stb_i, bus.wbs_adr_i, wbs_ack_q, wbs_dat_q, WB_BASE, WB_MASK};
`endif
  assign req = wb_rst_ni & (bus.cpu_stb_i | wb_req);
  assign acc = state_q == IDLE && req;
  assign we  = gnt == MST_WB ? bus.wbs_we_i : bus.cpu_we_i;
  assign sel = gnt == MST_WB ? bus.wbs_sel_i : bus.cpu_sel_i;
  assign adr = gnt == MST_WB ? bus.wbs_adr_i[ADDR_W+1:2] : bus.cpu_adr_i;
  assign dat = gnt == MST_WB ? bus.wbs_dat_i : bus.cpu_dat_i;
  always_comb begin
    cur       = state_q == IDLE ? gnt : gnt_q;
    state_d   = acc ? (we ? ACK : RDATA) : (state_q == RDATA ? ACK : IDLE);
    gnt_d     = acc ? gnt : gnt_q;
    cpu_ack_d = state_d == ACK && cur == MST_CPU;
    wbs_ack_d = state_d == ACK && cur == MST_WB && bus.wbs_cyc_i;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      gnt_q     <= MST_CPU;
      cpu_ack_q <= 1'b0;
      wbs_ack_q <= 1'b0;
      cpu_dat_q <= 32'h0;
      wbs_dat_q <= 32'h0;
      wmask_q   <= 4'h0;
      addr_q    <= '0;
      din_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cpu_ack_q <= cpu_ack_d;
      wbs_ack_q <= wbs_ack_d;
      if (acc) begin
        wmask_q <= sel;
        addr_q  <= adr;
        din_q   <= dat;
      end
      if (state_q == RDATA && gnt_q == MST_CPU) cpu_dat_q <= bus.dout0;
      if (state_q == RDATA && gnt_q == MST_WB) wbs_dat_q <= bus.dout0;
    end
  assign bus.cpu_ack_o = cpu_ack_q;
  assign bus.cpu_dat_o = cpu_dat_q;
  assign bus.csb0      = !acc;
  assign bus.web0      = !(acc && we && |sel);
  assign bus.wmask0    = acc ? sel : wmask_q;
  assign bus.addr0     = acc ? adr : addr_q;
  assign bus.din0      = acc ? dat : din_q;
endmodule
